// File: rtl/ps2_host_transmitter_if.sv
// ---------------------------------------------------------------------------
// ps2_host_transmitter_if
// CPU-side request/status bundle of the PS/2 host transmitter.
//   iData         : byte to send (sampled when the request is accepted)
//   iData_Ready   : request to send iData
//   oReadyForData : transmitter idle, next request will be accepted
//   oDone         : one-cycle pulse, byte sent and acknowledged by the device
//   oNack         : one-cycle pulse, device left data high in the ack slot
//   oTimeout      : one-cycle pulse, device clock stalled, frame aborted
// master = CPU core, slave = transmitter.
// ---------------------------------------------------------------------------
interface ps2_host_transmitter_if;
    logic [7:0] iData;
    logic       iData_Ready;
    logic       oReadyForData;
    logic       oDone;
    logic       oNack;
    logic       oTimeout;

    modport master (
        output iData, iData_Ready,
        input  oReadyForData, oDone, oNack, oTimeout
    );

    modport slave (
        input  iData, iData_Ready,
        output oReadyForData, oDone, oNack, oTimeout
    );
endinterface

// File: rtl/ps2_host_transmitter.sv
// ---------------------------------------------------------------------------
// ps2_host_transmitter
// Host-to-device PS/2 transmitter. Sends one command byte to the keyboard:
// inhibits the bus, issues the start bit, shifts D0..D7, odd parity and stop
// on device clock falling edges, then checks the device acknowledge.
// Ports:
//   Clock          : system clock
//   Reset          : asynchronous active-low reset
//   cpu            : request/status bundle (ps2_host_transmitter_if.slave)
//   iPS2_Clock     : PS/2 clock pin level (asynchronous)
//   iPS2_Data      : PS/2 data pin level (asynchronous)
//   oPS2_Clock_OE  : 1 = pull PS/2 clock low, 0 = release
//   oPS2_Data_OE   : 1 = pull PS/2 data low, 0 = release
// ---------------------------------------------------------------------------
module ps2_host_transmitter #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int START_CYCLES   = 250,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic                         Clock,
    input  logic                         Reset,
    ps2_host_transmitter_if.slave        cpu,
    input  logic                         iPS2_Clock,
    input  logic                         iPS2_Data,
    output logic                         oPS2_Clock_OE,
    output logic                         oPS2_Data_OE
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        START     = 3'd2,
        SEND      = 3'd3,
        ACK       = 3'd4,
        WAIT_IDLE = 3'd5
    } state_t;

    localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
    localparam logic [19:0] START_LAST   = 20'(START_CYCLES - 1);
    localparam logic [19:0] TIMEOUT_LAST = 20'(TIMEOUT_CYCLES - 1);

    // Odd parity: the parity bit makes the total count of ones odd.
    function automatic logic oddParity(input logic [7:0] b);
        return ~^b;
    endfunction

    state_t      state_r,   stateNx;
    logic [19:0] cnt_r,     cntNx;
    logic [3:0]  bitIdx_r,  bitIdxNx;
    logic [9:0]  frame_r,   frameNx;     // {stop, parity, D7..D0}
    logic        clockOe_r, clockOeNx;
    logic        dataOe_r,  dataOeNx;
    logic        ready_r,   readyNx;
    logic        done_r,    doneNx;
    logic        nack_r,    nackNx;
    logic        timeout_r, timeoutNx;

    logic clkMeta_r, clkSync_r, clkPrev_r;
    logic dataMeta_r, dataSync_r;
    logic        fallEdge_s;
    logic        timeoutHit_s;
    logic [19:0] cntInc_s;

    // Two-flop synchronizers for the device pins plus one history flop for edge detection.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            clkMeta_r  <= 1'b1;
            clkSync_r  <= 1'b1;
            clkPrev_r  <= 1'b1;
            dataMeta_r <= 1'b1;
            dataSync_r <= 1'b1;
        end else begin
            clkMeta_r  <= iPS2_Clock;
            clkSync_r  <= clkMeta_r;
            clkPrev_r  <= clkSync_r;
            dataMeta_r <= iPS2_Data;
            dataSync_r <= dataMeta_r;
        end
    end

    assign fallEdge_s   = clkPrev_r & ~clkSync_r;
    assign timeoutHit_s = (cnt_r == TIMEOUT_LAST);
    assign cntInc_s     = cnt_r + 20'd1;

    // Next-state and next-output logic; every output is registered from these values.
    always_comb begin
        stateNx   = state_r;
        cntNx     = cnt_r;
        bitIdxNx  = bitIdx_r;
        frameNx   = frame_r;
        clockOeNx = 1'b0;
        dataOeNx  = 1'b0;
        readyNx   = 1'b0;
        doneNx    = 1'b0;
        nackNx    = 1'b0;
        timeoutNx = 1'b0;
        case (state_r)
            IDLE: begin
                if (cpu.iData_Ready) begin
                    frameNx   = {1'b1, oddParity(cpu.iData), cpu.iData};
                    cntNx     = 20'd0;
                    bitIdxNx  = 4'd0;
                    clockOeNx = 1'b1;
                    stateNx   = INHIBIT;
                end else begin
                    readyNx   = 1'b1;
                end
            end
            INHIBIT: begin
                clockOeNx = 1'b1;
                if (cnt_r == INHIBIT_LAST) begin
                    cntNx    = 20'd0;
                    dataOeNx = 1'b1;
                    stateNx  = START;
                end else begin
                    cntNx    = cntInc_s;
                end
            end
            START: begin
                dataOeNx = 1'b1;
                if (cnt_r == START_LAST) begin
                    // Clock released here; the start bit stays on the data line.
                    cntNx     = 20'd0;
                    stateNx   = SEND;
                end else begin
                    clockOeNx = 1'b1;
                    cntNx     = cntInc_s;
                end
            end
            SEND: begin
                dataOeNx = dataOe_r;
                if (fallEdge_s) begin
                    // Edge n+1 presents frame bit n; the stop bit (1) releases data.
                    cntNx    = 20'd0;
                    dataOeNx = ~frame_r[bitIdx_r];
                    bitIdxNx = bitIdx_r + 4'd1;
                    if (bitIdx_r == 4'd9) begin
                        stateNx = ACK;
                    end else begin
                        stateNx = SEND;
                    end
                end else if (timeoutHit_s) begin
                    dataOeNx  = 1'b0;
                    timeoutNx = 1'b1;
                    readyNx   = 1'b1;
                    stateNx   = IDLE;
                end else begin
                    cntNx     = cntInc_s;
                end
            end
            ACK: begin
                if (fallEdge_s) begin
                    cntNx = 20'd0;
                    if (dataSync_r) begin
                        nackNx  = 1'b1;
                        readyNx = 1'b1;
                        stateNx = IDLE;
                    end else begin
                        stateNx = WAIT_IDLE;
                    end
                end else if (timeoutHit_s) begin
                    timeoutNx = 1'b1;
                    readyNx   = 1'b1;
                    stateNx   = IDLE;
                end else begin
                    cntNx     = cntInc_s;
                end
            end
            WAIT_IDLE: begin
                if (clkSync_r && dataSync_r) begin
                    doneNx    = 1'b1;
                    readyNx   = 1'b1;
                    stateNx   = IDLE;
                end else if (fallEdge_s) begin
                    cntNx     = 20'd0;
                end else if (timeoutHit_s) begin
                    timeoutNx = 1'b1;
                    readyNx   = 1'b1;
                    stateNx   = IDLE;
                end else begin
                    cntNx     = cntInc_s;
                end
            end
            default: begin
                readyNx = 1'b1;
                stateNx = IDLE;
            end
        endcase
    end

    // State, datapath and output registers; reset releases both lines immediately.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= IDLE;
            cnt_r     <= 20'd0;
            bitIdx_r  <= 4'd0;
            frame_r   <= 10'd0;
            clockOe_r <= 1'b0;
            dataOe_r  <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
            nack_r    <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= stateNx;
            cnt_r     <= cntNx;
            bitIdx_r  <= bitIdxNx;
            frame_r   <= frameNx;
            clockOe_r <= clockOeNx;
            dataOe_r  <= dataOeNx;
            ready_r   <= readyNx;
            done_r    <= doneNx;
            nack_r    <= nackNx;
            timeout_r <= timeoutNx;
        end
    end

    assign oPS2_Clock_OE     = clockOe_r;
    assign oPS2_Data_OE      = dataOe_r;
    assign cpu.oReadyForData = ready_r;
    assign cpu.oDone         = done_r;
    assign cpu.oNack         = nack_r;
    assign cpu.oTimeout      = timeout_r;

endmodule

// File: tb/tb_ps2_host_transmitter.sv
// ---------------------------------------------------------------------------
// tb_ps2_host_transmitter
// Drives command bytes into ps2_host_transmitter and plays the keyboard side
// with a clocking device model on open-drain lines. Received frames are compared
// against a frame built from the byte's bit values and its population count.
// ---------------------------------------------------------------------------
module tb_ps2_host_transmitter;

    localparam int INH = 60;    // inhibit cycles
    localparam int STC = 12;    // start-bit cycles
    localparam int TMO = 400;   // timeout cycles
    localparam int H   = 20;    // device clock half period in system cycles

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic devClk = 1'b1;
    logic devData = 1'b1;
    logic clockOe, dataOe;
    logic ps2Clk, ps2Data;

    int checks = 0;
    int errors = 0;
    int fallCount = 0;

    int totDone = 0, totNack = 0, totTo = 0;
    int totInh = 0, totStart = 0, totMulti = 0, totReadyBad = 0;

    ps2_host_transmitter_if cpuBus();

    // Open-drain lines: low if either side pulls them low.
    assign ps2Clk  = devClk  & ~clockOe;
    assign ps2Data = devData & ~dataOe;

    ps2_host_transmitter #(
        .INHIBIT_CYCLES(INH),
        .START_CYCLES  (STC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .Clock        (clk),
        .Reset        (rstN),
        .cpu          (cpuBus.slave),
        .iPS2_Clock   (ps2Clk),
        .iPS2_Data    (ps2Data),
        .oPS2_Clock_OE(clockOe),
        .oPS2_Data_OE (dataOe)
    );

    always #10 clk = ~clk;

    // Running totals of status pulses and line-driving phases, sampled mid-cycle.
    always @(negedge clk) begin
        if (cpuBus.oDone)    totDone <= totDone + 1;
        if (cpuBus.oNack)    totNack <= totNack + 1;
        if (cpuBus.oTimeout) totTo   <= totTo + 1;
        if (clockOe && !dataOe) totInh   <= totInh + 1;
        if (clockOe && dataOe)  totStart <= totStart + 1;
        if ((32'(cpuBus.oDone) + 32'(cpuBus.oNack) + 32'(cpuBus.oTimeout)) > 32'd1)
            totMulti <= totMulti + 1;
        if ((cpuBus.oDone || cpuBus.oNack || cpuBus.oTimeout) && !cpuBus.oReadyForData)
            totReadyBad <= totReadyBad + 1;
    end

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected line sequence: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] refFrame(input logic [7:0] b);
        logic [10:0] f;
        f = 11'd0;
        for (int i = 0; i < 8; i++) f[i + 1] = ((b >> i) & 8'd1) != 8'd0;
        f[9]  = ($countones(b) % 2) == 0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic issue(input logic [7:0] b);
        int n;
        n = 0;
        while (!cpuBus.oReadyForData && n < 500) begin
            @(negedge clk);
            n++;
        end
        cpuBus.iData = b;
        cpuBus.iData_Ready = 1'b1;
        @(negedge clk);
        cpuBus.iData_Ready = 1'b0;
        checkVal("busyAfterAccept", 32'(cpuBus.oReadyForData), 32'd0);
    endtask

    task automatic waitFall(input int n);
        int c;
        c = 0;
        while (fallCount < n && c < 3000) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic waitStatus(input int base);
        int c;
        c = 0;
        while ((totDone + totNack + totTo) <= base && c < TMO + 200) begin
            @(negedge clk);
            c++;
        end
        repeat (3) @(negedge clk);
    endtask

    // Device model: clocks the frame out of the host, samples data before each
    // rising edge, optionally acknowledges, optionally stops after edge stopAfter.
    task automatic device(input bit ackLow, input int stopAfter, input bit measureTo,
                          output logic [10:0] got);
        int c;
        bit seen;
        got = 11'd0;
        devClk = 1'b1;
        devData = 1'b1;
        c = 0;
        while (!(ps2Clk === 1'b1 && ps2Data === 1'b0) && c < INH + STC + 600) begin
            @(negedge clk);
            c++;
        end
        if (!(ps2Clk === 1'b1 && ps2Data === 1'b0)) begin
            checkVal("startCondition", 32'd0, 32'd1);
            return;
        end
        got[0] = ps2Data;
        for (int n = 1; n <= 11; n++) begin
            repeat (H) @(negedge clk);
            devClk = 1'b0;
            fallCount = n;
            if (n == stopAfter) begin
                if (measureTo) begin
                    // Pin fall reaches the counter after the 3-clock detection latency.
                    c = 0;
                    seen = 1'b0;
                    while (!seen && c < TMO + 50) begin
                        @(posedge clk);
                        #1;
                        c++;
                        if (cpuBus.oTimeout) seen = 1'b1;
                    end
                    checkVal("timeoutLatency", 32'(c), 32'(TMO + 3));
                end else begin
                    repeat (H) @(negedge clk);
                end
                devClk = 1'b1;
                devData = 1'b1;
                return;
            end
            repeat (H) @(negedge clk);
            if (n <= 10) got[n] = ps2Data;
            if (n == 10 && ackLow) devData = 1'b0;
            if (n == 11) devData = 1'b1;
            devClk = 1'b1;
        end
    endtask

    task automatic sendAndCheck(input logic [7:0] b, input bit ackLow, input bit injectReq);
        logic [10:0] got, exp;
        int bDone, bNack, bTo, bInh, bStart;
        bDone = totDone; bNack = totNack; bTo = totTo; bInh = totInh; bStart = totStart;
        fallCount = 0;
        fork
            device(ackLow, 11, 1'b0, got);
            begin
                issue(b);
                if (injectReq) begin
                    waitFall(3);
                    @(negedge clk);
                    cpuBus.iData = 8'h55;
                    cpuBus.iData_Ready = 1'b1;
                    @(negedge clk);
                    cpuBus.iData_Ready = 1'b0;
                end
            end
        join
        waitStatus(bDone + bNack + bTo);
        exp = refFrame(b);
        checkVal("frame", 32'(got), 32'(exp));
        checkVal("parity", 32'(got[9]), 32'(exp[9]));
        checkVal("inhibitLen", 32'(totInh - bInh), 32'(INH));
        checkVal("startLen", 32'(totStart - bStart), 32'(STC));
        checkVal("status", 32'(((totDone - bDone) << 8) | ((totNack - bNack) << 4) | (totTo - bTo)),
                 ackLow ? 32'h100 : 32'h010);
        checkVal("linesReleased", 32'({clockOe, dataOe}), 32'd0);
        checkVal("readyAfter", 32'(cpuBus.oReadyForData), 32'd1);
    endtask

    initial begin
        logic [10:0] got;
        int bDone, bNack, bTo, bInh;
        cpuBus.iData = 8'h00;
        cpuBus.iData_Ready = 1'b0;
        repeat (3) @(negedge clk);
        checkVal("resetLines", 32'({clockOe, dataOe}), 32'd0);
        checkVal("resetReady", 32'(cpuBus.oReadyForData), 32'd1);
        checkVal("resetStatus", 32'({cpuBus.oDone, cpuBus.oNack, cpuBus.oTimeout}), 32'd0);
        rstN = 1'b1;
        repeat (3) @(negedge clk);
        checkVal("idleReady", 32'(cpuBus.oReadyForData), 32'd1);

        sendAndCheck(8'hED, 1'b1, 1'b0);
        sendAndCheck(8'h00, 1'b1, 1'b0);
        sendAndCheck(8'hFF, 1'b1, 1'b0);
        sendAndCheck(8'h01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) sendAndCheck(8'($urandom_range(0, 255)), 1'b1, 1'b0);

        // Device never acknowledges, then the next request must go through.
        sendAndCheck(8'($urandom_range(0, 255)), 1'b0, 1'b0);
        sendAndCheck(8'hA5, 1'b1, 1'b0);

        // Device stalls after the fourth falling edge.
        bDone = totDone; bNack = totNack; bTo = totTo;
        fallCount = 0;
        fork
            device(1'b1, 4, 1'b1, got);
            issue(8'h3C);
        join
        waitStatus(bDone + bNack + bTo);
        checkVal("timeoutStatus", 32'(((totDone - bDone) << 8) | ((totNack - bNack) << 4) | (totTo - bTo)),
                 32'h001);
        checkVal("timeoutLines", 32'({clockOe, dataOe}), 32'd0);
        checkVal("timeoutReady", 32'(cpuBus.oReadyForData), 32'd1);

        // Stray request during an active frame is dropped.
        sendAndCheck(8'hED, 1'b1, 1'b1);
        bInh = totInh;
        repeat (INH + 50) @(negedge clk);
        checkVal("noSecondFrame", 32'(totInh - bInh), 32'd0);

        // Reset while D5 of 0x00 (a driven 0) is on the line.
        bDone = totDone; bNack = totNack; bTo = totTo;
        fallCount = 0;
        fork
            device(1'b1, 6, 1'b0, got);
            begin
                issue(8'h00);
                waitFall(6);
                repeat (5) @(negedge clk);
                checkVal("bit5Driven", 32'(dataOe), 32'd1);
                #3 rstN = 1'b0;
                #1;
                checkVal("asyncRelease", 32'({clockOe, dataOe}), 32'd0);
                repeat (3) @(negedge clk);
                rstN = 1'b1;
                @(negedge clk);
                checkVal("readyAfterReset", 32'(cpuBus.oReadyForData), 32'd1);
            end
        join
        repeat (50) @(negedge clk);
        checkVal("resetNoStatus", 32'((totDone - bDone) + (totNack - bNack) + (totTo - bTo)), 32'd0);
        sendAndCheck(8'hF4, 1'b1, 1'b0);

        checkVal("exclusiveStatus", 32'(totMulti), 32'd0);
        checkVal("readyWithStatus", 32'(totReadyBad), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop if something stalls beyond every bounded wait.
    initial begin
        #1500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1);
    end

endmodule
